// File: rtl/bus_hub.sv
// Shared-bus hub: priority-resolved data bus, CPU phase tracker locked to sync,
// and contention/sync error capture with saturating event count.
module bus_hub #(
  parameter int                 NUM_DEV = 8,
  parameter int                 DATA_W  = 4,
  parameter int                 CNT_W   = 8,
  parameter logic [DATA_W-1:0]  PARK    = '0
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        halt,
  input  logic                        sync,
  input  logic [NUM_DEV*DATA_W-1:0]   dev_data,
  input  logic [NUM_DEV-1:0]          dev_en,
  input  logic                        clear_err,
  output logic [DATA_W-1:0]           bus,
  output logic [2:0]                  phase,
  output logic                        phase_valid,
  output logic                        sync_err,
  output logic                        contention,
  output logic [CNT_W-1:0]            err_count,
  output logic [NUM_DEV-1:0]          first_mask,
  output logic [2:0]                  first_phase
);

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [2:0]        phase_d;
  logic              serr_set;
  logic              multi;
  logic [NUM_DEV-1:0] en_m1;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Lowest-index enabled device wins; scan from the top so the lowest overwrites last.
  always_comb begin
    bus = PARK;
    for (int i = NUM_DEV - 1; i >= 0; i--) begin
      if (dev_en[i]) bus = dev_data[i*DATA_W +: DATA_W];
    end
  end

  // Clearing the lowest set bit leaves something only when two or more are set.
  assign en_m1 = dev_en - {{(NUM_DEV-1){1'b0}}, 1'b1};
  assign multi = |(dev_en & en_m1);

  always_comb begin
    state_d  = state_q;
    phase_d  = phase;
    serr_set = 1'b0;
    case (state_q)
      UNLOCKED: begin
        phase_d = 3'd0;
        if (sync) state_d = LOCKED;
      end
      LOCKED: begin
        if (!halt) begin
          if (sync) begin
            phase_d  = 3'd0;
            serr_set = (phase != 3'd7);
          end else if (phase == 3'd7) begin
            phase_d  = 3'd0;
            state_d  = UNLOCKED;
            serr_set = 1'b1;
          end else begin
            phase_d = phase + 3'd1;
          end
        end
      end
      default: begin
        state_d = UNLOCKED;
        phase_d = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= UNLOCKED;
      phase   <= 3'd0;
    end else begin
      state_q <= state_d;
      phase   <= phase_d;
    end
  end

  assign phase_valid = (state_q == LOCKED);

  // Error capture: a fresh event on the same cycle as clear_err survives the clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_err    <= 1'b0;
      contention  <= 1'b0;
      err_count   <= '0;
      first_mask  <= '0;
      first_phase <= 3'd0;
    end else begin
      contention <= multi;

      if (serr_set)       sync_err <= 1'b1;
      else if (clear_err) sync_err <= 1'b0;

      if (clear_err)                        err_count <= multi ? {{(CNT_W-1){1'b0}}, 1'b1} : '0;
      else if (multi && err_count != CNT_MAX) err_count <= err_count + 1'b1;

      if (multi && (clear_err || err_count == '0)) begin
        first_mask  <= dev_en;
        first_phase <= phase;
      end else if (clear_err) begin
        first_mask  <= '0;
        first_phase <= 3'd0;
      end
    end
  end

endmodule

// File: tb/tb_bus_hub.sv
// Directed bench for bus_hub: bus priority, phase lock/realign, error capture,
// saturation, clear collisions, halt and reset behaviour.
module tb_bus_hub;

  localparam int NUM_DEV = 8;
  localparam int DATA_W  = 4;
  localparam int CNT_W   = 3;
  localparam logic [DATA_W-1:0] PARK = 4'hC;

  logic                      clock = 1'b0;
  logic                      reset, halt, sync, clear_err;
  logic [NUM_DEV*DATA_W-1:0] dev_data;
  logic [NUM_DEV-1:0]        dev_en;
  logic [DATA_W-1:0]         bus;
  logic [2:0]                phase, first_phase;
  logic                      phase_valid, sync_err, contention;
  logic [CNT_W-1:0]          err_count;
  logic [NUM_DEV-1:0]        first_mask;

  int n_cmp = 0;
  int n_err = 0;

  bus_hub #(.NUM_DEV(NUM_DEV), .DATA_W(DATA_W), .CNT_W(CNT_W), .PARK(PARK)) dut (
    .clock(clock), .reset(reset), .halt(halt), .sync(sync),
    .dev_data(dev_data), .dev_en(dev_en), .clear_err(clear_err),
    .bus(bus), .phase(phase), .phase_valid(phase_valid), .sync_err(sync_err),
    .contention(contention), .err_count(err_count),
    .first_mask(first_mask), .first_phase(first_phase)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; halt = 1'b0; sync = 1'b0; clear_err = 1'b0;
    dev_en = '0;
    // device nibbles 7..0 = 7,6,5,4,3,5,A,0
    dev_data = 32'h765435A0;
    step(); step();
    chk("rst_phase", phase, 0);
    chk("rst_valid", phase_valid, 0);
    chk("rst_serr", sync_err, 0);
    chk("rst_cont", contention, 0);
    chk("rst_cnt", err_count, 0);
    chk("rst_mask", first_mask, 0);
    chk("rst_fphase", first_phase, 0);
    #1 chk("bus_park", bus, 4'hC);
    reset = 1'b0;

    // Priority mux and first contention
    dev_en = 8'b00000110;
    #1 chk("bus_prio", bus, 4'hA);
    step();
    chk("mux_cont", contention, 1);
    chk("mux_cnt", err_count, 1);
    chk("mux_mask", first_mask, 8'h06);
    chk("mux_fphase", first_phase, 0);
    dev_en = 8'b10000000;
    #1 chk("bus_dev7", bus, 4'h7);
    step();
    chk("single_nocont", contention, 0);
    chk("single_cnt", err_count, 1);
    dev_en = 8'b00010100;
    #1 chk("bus_dev2", bus, 4'h5);
    step();
    chk("second_cnt", err_count, 2);
    chk("second_mask_hold", first_mask, 8'h06);
    dev_en = '0; clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    chk("clr_cnt", err_count, 0);
    chk("clr_mask", first_mask, 0);

    // Lock and run two full CPU cycles
    sync = 1'b1;
    step();
    chk("lock_valid", phase_valid, 1);
    chk("lock_phase", phase, 0);
    for (int k = 1; k <= 16; k++) begin
      sync = ((k - 1) % 8 == 7);
      step();
      chk($sformatf("run_phase%0d", k), phase, k % 8);
      chk($sformatf("run_valid%0d", k), phase_valid, 1);
    end
    chk("run_serr", sync_err, 0);

    // Early sync at phase 3
    sync = 1'b0;
    step(); step(); step();
    chk("pre_early", phase, 3);
    sync = 1'b1;
    step();
    chk("early_serr", sync_err, 1);
    chk("early_phase", phase, 0);
    sync = 1'b0;
    for (int k = 0; k < 7; k++) step();
    chk("pre_miss", phase, 7);
    step();
    chk("miss_valid", phase_valid, 0);
    chk("miss_phase", phase, 0);
    step(); step();
    chk("unl_valid", phase_valid, 0);
    chk("unl_phase", phase, 0);
    chk("serr_sticky", sync_err, 1);
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    chk("serr_clr", sync_err, 0);

    // Clear coinciding with a sync error: the error wins
    sync = 1'b1; step();
    sync = 1'b0; step();
    chk("relock_phase", phase, 1);
    sync = 1'b1; clear_err = 1'b1;
    step();
    sync = 1'b0; clear_err = 1'b0;
    chk("clrcoll_serr", sync_err, 1);
    chk("clrcoll_phase", phase, 0);

    // Build err_count=5, then clear with a contention at phase 4
    dev_en = 8'b00000011;
    for (int k = 0; k < 5; k++) step();
    chk("build_cnt", err_count, 5);
    chk("build_mask", first_mask, 8'h03);
    chk("build_fphase", first_phase, 0);
    dev_en = '0;
    step(); step();
    chk("build_ph7", phase, 7);
    sync = 1'b1; step();
    sync = 1'b0;
    for (int k = 0; k < 4; k++) step();
    chk("pre_cc_phase", phase, 4);
    dev_en = 8'b00001001; clear_err = 1'b1;
    step();
    dev_en = '0; clear_err = 1'b0;
    chk("cc_cnt", err_count, 1);
    chk("cc_mask", first_mask, 8'h09);
    chk("cc_fphase", first_phase, 4);
    chk("cc_serr", sync_err, 0);

    // Saturation under halt (phase frozen at 6)
    clear_err = 1'b1; step(); clear_err = 1'b0;
    chk("sat_pre_cnt", err_count, 0);
    chk("sat_pre_phase", phase, 6);
    halt = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      dev_en = (k == 1) ? 8'b11000000 : 8'b00000011;
      step();
      chk($sformatf("sat_cont%0d", k), contention, 1);
      chk($sformatf("sat_cnt%0d", k), err_count, (k > 7) ? 7 : k);
    end
    dev_en = '0; halt = 1'b0;
    step();
    chk("sat_end_cont", contention, 0);
    chk("sat_end_cnt", err_count, 7);
    chk("sat_mask", first_mask, 8'hC0);
    chk("sat_fphase", first_phase, 6);
    chk("sat_phase_held", phase, 7);

    // Halt at phase 5 ignores sync
    sync = 1'b1; step(); sync = 1'b0;
    for (int k = 0; k < 5; k++) step();
    chk("pre_halt", phase, 5);
    halt = 1'b1; sync = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk($sformatf("halt_phase%0d", k), phase, 5);
    end
    chk("halt_serr", sync_err, 0);
    chk("halt_valid", phase_valid, 1);
    halt = 1'b0; sync = 1'b0;
    step();
    chk("unhalt_phase", phase, 6);

    // Reset overrides pending contention, sync and clear
    reset = 1'b1; dev_en = 8'b00000110; sync = 1'b1; clear_err = 1'b1;
    #1 chk("rst_bus_comb", bus, 4'hA);
    step();
    chk("mid_rst_phase", phase, 0);
    chk("mid_rst_valid", phase_valid, 0);
    chk("mid_rst_cont", contention, 0);
    chk("mid_rst_cnt", err_count, 0);
    chk("mid_rst_mask", first_mask, 0);
    chk("mid_rst_fphase", first_phase, 0);
    chk("mid_rst_serr", sync_err, 0);
    reset = 1'b0; dev_en = '0; sync = 1'b0; clear_err = 1'b0;
    step(); step(); step();
    chk("norelock_valid", phase_valid, 0);
    chk("norelock_phase", phase, 0);
    sync = 1'b1; step(); sync = 1'b0;
    chk("relock2_valid", phase_valid, 1);
    step();
    chk("relock2_phase", phase, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
